// File: rtl/alu_pkg.sv
// Shared opcode map, scheduler state encoding and latency helper for the ALU scheduler.
package alu_pkg;

    localparam int unsigned OP_W = 4;

    localparam logic [OP_W-1:0] OP_ADD  = 4'b0000;
    localparam logic [OP_W-1:0] OP_SUB  = 4'b0001;
    localparam logic [OP_W-1:0] OP_AND  = 4'b0010;
    localparam logic [OP_W-1:0] OP_OR   = 4'b0011;
    localparam logic [OP_W-1:0] OP_XOR  = 4'b0100;
    localparam logic [OP_W-1:0] OP_NOTA = 4'b0101;
    localparam logic [OP_W-1:0] OP_NAND = 4'b0110;
    localparam logic [OP_W-1:0] OP_NOR  = 4'b0111;
    localparam logic [OP_W-1:0] OP_XNOR = 4'b1000;
    localparam logic [OP_W-1:0] OP_RAND = 4'b1001;
    localparam logic [OP_W-1:0] OP_ROR  = 4'b1010;
    localparam logic [OP_W-1:0] OP_RXOR = 4'b1011;
    localparam logic [OP_W-1:0] OP_PASS = 4'b1100;
    localparam logic [OP_W-1:0] OP_BMA  = 4'b1101;
    localparam logic [OP_W-1:0] OP_AMB  = 4'b1110;
    localparam logic [OP_W-1:0] OP_MUL  = 4'b1111;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_RESP  = 2'd3
    } sched_state_t;

    // Only the sequential multiplier needs the long latency.
    function automatic int unsigned op_latency(input logic [OP_W-1:0] op,
                                               input int unsigned mul_lat,
                                               input int unsigned alu_lat);
        return (op == OP_MUL) ? mul_lat : alu_lat;
    endfunction

endpackage

// File: rtl/alu_op_scheduler_rr_arb2.sv
// Two-input round-robin arbiter; the requester that did not win last time has priority.
module rr_arb2 (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic [1:0] req,
    input  logic       accept,
    output logic [1:0] grant
);

    logic rr_last;

    // Remember who was granted on the last accepted request.
    always_ff @(posedge clk) begin
        if (rst) begin
            rr_last <= 1'b1;
        end else if (accept) begin
            rr_last <= grant[1];
        end
    end

    // One-hot grant, zero when disabled or nobody requests.
    always_comb begin
        grant = 2'b00;
        if (en) begin
            case (req)
                2'b01:   grant = 2'b01;
                2'b10:   grant = 2'b10;
                2'b11:   grant = rr_last ? 2'b01 : 2'b10;
                default: grant = 2'b00;
            endcase
        end
    end

endmodule

// File: rtl/alu_op_scheduler.sv
// Shares one ALU between two requesters: arbitrate, issue, wait op latency, return result.
module alu_op_scheduler
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH   = 8,
    parameter int unsigned ALU_LAT = 1,
    parameter int unsigned MUL_LAT = 9
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 req0_valid,
    output logic                 req0_ready,
    input  logic [WIDTH-1:0]     req0_a,
    input  logic [WIDTH-1:0]     req0_b,
    input  logic [OP_W-1:0]      req0_op,
    input  logic                 req1_valid,
    output logic                 req1_ready,
    input  logic [WIDTH-1:0]     req1_a,
    input  logic [WIDTH-1:0]     req1_b,
    input  logic [OP_W-1:0]      req1_op,
    output logic [WIDTH-1:0]     alu_a,
    output logic [WIDTH-1:0]     alu_b,
    output logic [OP_W-1:0]      alu_op,
    output logic                 alu_mul_start,
    input  logic [2*WIDTH-1:0]   alu_s,
    input  logic                 alu_cout,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic                 rsp_id,
    output logic [2*WIDTH-1:0]   rsp_data,
    output logic                 rsp_cout,
    output logic                 busy,
    output logic [15:0]          op_count
);

    localparam int unsigned RES_W   = 2 * WIDTH;
    localparam int unsigned CNT_MAX = (MUL_LAT > ALU_LAT) ? MUL_LAT : ALU_LAT;
    localparam int unsigned CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
    localparam int unsigned OPC_W   = 16;

    sched_state_t         state_q, state_n;
    logic [CNT_W-1:0]     cnt_q, cnt_n;
    logic                 id_q, id_n;
    logic [WIDTH-1:0]     alu_a_n, alu_b_n;
    logic [OP_W-1:0]      alu_op_n;
    logic                 mul_start_n;
    logic                 rsp_valid_n, rsp_id_n, rsp_cout_n, busy_n;
    logic [RES_W-1:0]     rsp_data_n;
    logic [OPC_W-1:0]     op_count_n;
    logic [1:0]           grant;
    logic                 sel;

    rr_arb2 u_arb (
        .clk    (clk),
        .rst    (rst),
        .en     (state_q == S_IDLE),
        .req    ({req1_valid, req0_valid}),
        .accept (|grant),
        .grant  (grant)
    );

    assign req0_ready = grant[0];
    assign req1_ready = grant[1];
    assign sel        = grant[1];

    // State and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= S_IDLE;
            cnt_q         <= '0;
            id_q          <= 1'b0;
            alu_a         <= '0;
            alu_b         <= '0;
            alu_op        <= '0;
            alu_mul_start <= 1'b0;
            rsp_valid     <= 1'b0;
            rsp_id        <= 1'b0;
            rsp_data      <= '0;
            rsp_cout      <= 1'b0;
            busy          <= 1'b0;
            op_count      <= '0;
        end else begin
            state_q       <= state_n;
            cnt_q         <= cnt_n;
            id_q          <= id_n;
            alu_a         <= alu_a_n;
            alu_b         <= alu_b_n;
            alu_op        <= alu_op_n;
            alu_mul_start <= mul_start_n;
            rsp_valid     <= rsp_valid_n;
            rsp_id        <= rsp_id_n;
            rsp_data      <= rsp_data_n;
            rsp_cout      <= rsp_cout_n;
            busy          <= busy_n;
            op_count      <= op_count_n;
        end
    end

    // Next-state and next-output logic; ALU bus is loaded on acceptance so it is valid in ISSUE.
    always_comb begin
        state_n     = state_q;
        cnt_n       = cnt_q;
        id_n        = id_q;
        alu_a_n     = alu_a;
        alu_b_n     = alu_b;
        alu_op_n    = alu_op;
        mul_start_n = 1'b0;
        rsp_valid_n = rsp_valid;
        rsp_id_n    = rsp_id;
        rsp_data_n  = rsp_data;
        rsp_cout_n  = rsp_cout;
        op_count_n  = op_count;

        case (state_q)
            S_IDLE: begin
                if (|grant) begin
                    alu_a_n     = sel ? req1_a  : req0_a;
                    alu_b_n     = sel ? req1_b  : req0_b;
                    alu_op_n    = sel ? req1_op : req0_op;
                    mul_start_n = (alu_op_n == OP_MUL);
                    id_n        = sel;
                    state_n     = S_ISSUE;
                end
            end
            S_ISSUE: begin
                cnt_n   = CNT_W'(op_latency(alu_op, MUL_LAT, ALU_LAT) - 1);
                state_n = S_WAIT;
            end
            S_WAIT: begin
                if (cnt_q == '0) begin
                    rsp_data_n  = alu_s;
                    rsp_cout_n  = alu_cout;
                    rsp_id_n    = id_q;
                    rsp_valid_n = 1'b1;
                    state_n     = S_RESP;
                end else begin
                    cnt_n = cnt_q - CNT_W'(1);
                end
            end
            S_RESP: begin
                if (rsp_ready) begin
                    rsp_valid_n = 1'b0;
                    op_count_n  = op_count + OPC_W'(1);
                    state_n     = S_IDLE;
                end
            end
            default: state_n = S_IDLE;
        endcase

        busy_n = (state_n != S_IDLE);
    end

endmodule

// File: tb/tb_alu_op_scheduler.sv
// Directed-plus-random bench for alu_op_scheduler with a transaction-level reference model.
module tb_alu_op_scheduler;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req0_valid = 1'b0, req1_valid = 1'b0;
    logic        req0_ready, req1_ready;
    logic [7:0]  req0_a = '0, req0_b = '0, req1_a = '0, req1_b = '0;
    logic [3:0]  req0_op = '0, req1_op = '0;
    logic [7:0]  alu_a, alu_b;
    logic [3:0]  alu_op;
    logic        alu_mul_start;
    logic [15:0] alu_s;
    logic        alu_cout;
    logic        rsp_valid;
    logic        rsp_ready = 1'b1;
    logic        rsp_id;
    logic [15:0] rsp_data;
    logic        rsp_cout;
    logic        busy;
    logic [15:0] op_count;

    int          n_cmp = 0;
    int          n_err = 0;
    int          cyc = 0;
    logic [7:0]  mul_age = '0;
    bit          last_win = 1'b1;
    logic [15:0] exp_cnt = '0;

    alu_op_scheduler #(.WIDTH(8), .ALU_LAT(1), .MUL_LAT(9)) dut (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b), .req0_op(req0_op),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b), .req1_op(req1_op),
        .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_mul_start(alu_mul_start),
        .alu_s(alu_s), .alu_cout(alu_cout),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_data(rsp_data),
        .rsp_cout(rsp_cout), .busy(busy), .op_count(op_count)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Behavioural ALU result: {cout, s}.
    function automatic logic [16:0] ref_alu(input logic [7:0] a, input logic [7:0] b, input logic [3:0] op);
        logic [8:0]  t;
        logic [15:0] p;
        case (op)
            4'h0: begin t = {1'b0, a} + {1'b0, b}; return {t[8], 7'b0, t}; end
            4'h1: begin t = {1'b0, a} - {1'b0, b}; return {~t[8], 7'b0, t}; end
            4'hF: begin p = 16'(a) * 16'(b); return {1'b0, p}; end
            default: return {^(a & b), op, 4'h0, a ^ b ^ {op, op}};
        endcase
    endfunction

    // Environment ALU: multiplier result only valid 9 cycles after its start pulse.
    always @(posedge clk) begin
        if (alu_mul_start) mul_age <= 8'd1;
        else if (mul_age != 8'hFF) mul_age <= mul_age + 8'd1;
    end

    always_comb begin
        logic [16:0] r;
        r = ref_alu(alu_a, alu_b, alu_op);
        if (alu_op == 4'hF && mul_age < 8'd9) begin
            alu_s    = 16'hBAD0 ^ 16'(mul_age);
            alu_cout = 1'b1;
        end else begin
            alu_s    = r[15:0];
            alu_cout = r[16];
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic rnd_req(input bit id);
        logic [3:0] op;
        op = ($urandom_range(0, 3) == 0) ? 4'hF : 4'($urandom_range(0, 14));
        if (id) begin req1_a = 8'($urandom); req1_b = 8'($urandom); req1_op = op; end
        else    begin req0_a = 8'($urandom); req0_b = 8'($urandom); req0_op = op; end
    endtask

    // Serve one command end to end; keep=1 re-arms the winner, hold>0 stalls the response.
    task automatic serve(input bit keep, input int hold);
        int          t;
        int          k;
        int          lat;
        bit          w;
        bit          bad;
        logic [7:0]  ea, eb;
        logic [3:0]  eo;
        logic [16:0] r;
        #1;
        t = 0;
        while (!(req0_ready || req1_ready) && t < 50) begin tick(); t++; end
        chk("accept", 32'(req0_ready | req1_ready), 32'd1);
        w = (req0_valid && req1_valid) ? !last_win : req1_valid;
        chk("grant0", 32'(req0_ready), 32'(!w));
        chk("grant1", 32'(req1_ready), 32'(w));
        ea = w ? req1_a : req0_a;
        eb = w ? req1_b : req0_b;
        eo = w ? req1_op : req0_op;
        k = cyc;
        last_win = w;
        tick();
        chk("issue_a", 32'(alu_a), 32'(ea));
        chk("issue_b", 32'(alu_b), 32'(eb));
        chk("issue_op", 32'(alu_op), 32'(eo));
        chk("mul_start", 32'(alu_mul_start), 32'(eo == 4'hF));
        if (keep) rnd_req(w);
        else if (w) req1_valid = 1'b0;
        else req0_valid = 1'b0;
        lat = (eo == 4'hF) ? 9 : 1;
        t = 0;
        while (!rsp_valid && t < 40) begin
            tick();
            t++;
            if (t == 1) chk("mul_start_pulse", 32'(alu_mul_start), 32'd0);
        end
        r = ref_alu(ea, eb, eo);
        chk("latency", 32'(cyc - k), 32'(2 + lat));
        chk("rsp_id", 32'(rsp_id), 32'(w));
        chk("rsp_data", 32'(rsp_data), 32'(r[15:0]));
        chk("rsp_cout", 32'(rsp_cout), 32'(r[16]));
        chk("busy_resp", 32'(busy), 32'd1);
        chk("ready_in_resp", 32'(req0_ready | req1_ready), 32'd0);
        chk("operands_held", 32'({alu_a, alu_b, alu_op}), 32'({ea, eb, eo}));
        if (hold > 0) begin
            bad = 1'b0;
            rsp_ready = 1'b0;
            repeat (hold) begin
                tick();
                if (rsp_valid !== 1'b1 || rsp_data !== r[15:0] || rsp_id !== w || rsp_cout !== r[16] ||
                    req0_ready !== 1'b0 || req1_ready !== 1'b0 || busy !== 1'b1 || op_count !== exp_cnt)
                    bad = 1'b1;
            end
            chk("stall_stable", 32'(bad), 32'd0);
            rsp_ready = 1'b1;
        end
        tick();
        exp_cnt = exp_cnt + 16'd1;
        chk("op_count", 32'(op_count), 32'(exp_cnt));
        chk("rsp_drop", 32'(rsp_valid), 32'd0);
        chk("busy_idle", 32'(busy), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int t;
        int k;
        int pat;

        // Reset values.
        repeat (3) tick();
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst_alu_bus", 32'({alu_a, alu_b, alu_op, alu_mul_start}), 32'd0);
        chk("rst_rsp", 32'({rsp_id, rsp_data, rsp_cout}), 32'd0);
        chk("rst_op_count", 32'(op_count), 32'd0);
        rst = 1'b0;

        // Reset in the middle of a multiply.
        req1_a = 8'h55; req1_b = 8'h66; req1_op = 4'hF; req1_valid = 1'b1;
        #1;
        t = 0;
        while (!req1_ready && t < 20) begin tick(); t++; end
        chk("mm_accept", 32'(req1_ready), 32'd1);
        k = cyc;
        tick();
        req1_valid = 1'b0;
        while (cyc < k + 5) tick();
        rst = 1'b1;
        tick();
        chk("mm_busy", 32'(busy), 32'd0);
        chk("mm_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("mm_alu_bus", 32'({alu_a, alu_b, alu_op, alu_mul_start}), 32'd0);
        chk("mm_op_count", 32'(op_count), 32'(exp_cnt));
        rst = 1'b0;
        last_win = 1'b1;
        req0_valid = 1'b1; req1_valid = 1'b1;
        rnd_req(1'b0); req0_op = 4'h2;
        rnd_req(1'b1); req1_op = 4'h3;
        serve(1'b0, 0);
        req0_valid = 1'b0; req1_valid = 1'b0;

        // Single add.
        req0_a = 8'hE3; req0_b = 8'h7B; req0_op = 4'h0; req0_valid = 1'b1;
        serve(1'b0, 0);

        // Multiply from requester 1.
        req1_a = 8'h8E; req1_b = 8'h12; req1_op = 4'hF; req1_valid = 1'b1;
        serve(1'b0, 0);

        // Continuous contention: grants must alternate.
        rnd_req(1'b0); rnd_req(1'b1);
        req0_valid = 1'b1; req1_valid = 1'b1;
        repeat (4) serve(1'b1, 0);
        req0_valid = 1'b0; req1_valid = 1'b0;

        // Response backpressure for 20 cycles.
        req0_a = 8'h3C; req0_b = 8'hC3; req0_op = 4'hD; req0_valid = 1'b1;
        serve(1'b0, 20);
        tick();
        chk("bp_idle", 32'({busy, rsp_valid}), 32'd0);

        // Random traffic.
        for (int i = 0; i < 10; i++) begin
            pat = $urandom_range(0, 2);
            rnd_req(1'b0); rnd_req(1'b1);
            req0_valid = (pat != 1);
            req1_valid = (pat != 0);
            serve(1'b0, 0);
            req0_valid = 1'b0; req1_valid = 1'b0;
        end

        // op_count wrap.
        force dut.op_count = 16'hFFFF;
        tick();
        release dut.op_count;
        exp_cnt = 16'hFFFF;
        req1_a = 8'h01; req1_b = 8'h02; req1_op = 4'h1; req1_valid = 1'b1;
        serve(1'b0, 0);
        chk("wrap_zero", 32'(op_count), 32'h0000);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/alu_op_scheduler.md
Name: alu_op_scheduler

Overview:
- Shares one 8-bit ALU datapath (add/sub/logic/reduction/multiply, 4-bit opcode) between two requesters.
- Accepts commands on per-requester valid/ready ports and arbitrates round-robin.
- Drives the ALU operand/opcode bus, holds it stable for the op-dependent latency, then returns the 16-bit result tagged with the requester id.
- Sits between the ALU and its command sources. It is the only block that drives the ALU inputs.

Parameters:
- WIDTH, 8, operand width; result width is 2*WIDTH.
- ALU_LAT, 1, cycles from issue to valid alu_s for opcodes 0000-1110; must be >=1.
- MUL_LAT, 9, cycles from issue to valid alu_s for opcode 1111 (multiply); must be >=1.

Ports:
- clk  in  1  single clock, all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- req0_valid  in  1  requester 0 command valid.
- req0_ready  out  1  requester 0 command accepted this cycle when high with valid.
- req0_a, req0_b  in  WIDTH  requester 0 operands.
- req0_op  in  4  requester 0 opcode.
- req1_valid, req1_ready, req1_a, req1_b, req1_op: same as above, for requester 1.
- alu_a, alu_b  out  WIDTH  ALU operands.
- alu_op  out  4  ALU opcode.
- alu_mul_start  out  1  one-cycle pulse; clears/starts the sequential multiplier.
- alu_s  in  2*WIDTH  ALU result.
- alu_cout  in  1  ALU carry out.
- rsp_valid  out  1  response valid.
- rsp_ready  in  1  response consumer ready.
- rsp_id  out  1  requester that issued the command.
- rsp_data  out  2*WIDTH  captured alu_s.
- rsp_cout  out  1  captured alu_cout.
- busy  out  1  high in any state other than IDLE.
- op_count  out  16  completed responses; wraps 0xFFFF->0.

Behaviour:
- States: IDLE, ISSUE, WAIT, RESP. Encoding lives in the package.
- Reset values: state=IDLE, all outputs 0, rr_last=1 (so requester 0 wins first), op_count=0.
- IDLE:
  - reqN_ready is asserted only for the arbitration winner and only when state is IDLE.
  - Only one requester: it wins.
  - Both requesting: the one not equal to rr_last wins.
  - On handshake: latch a, b, op and id; set rr_last=id; go to ISSUE.
- ISSUE (1 cycle):
  - Drive alu_a/alu_b/alu_op from the latched values.
  - alu_mul_start=1 only if op==4'b1111.
  - Load the counter with (op==4'b1111 ? MUL_LAT : ALU_LAT)-1; go to WAIT.
- WAIT:
  - alu_a/b/op stay stable.
  - Decrement the counter each cycle. In the cycle the counter is 0, capture alu_s and alu_cout on the edge and go to RESP.
- RESP:
  - rsp_valid=1, with rsp_id/rsp_data/rsp_cout held stable until rsp_valid&&rsp_ready.
  - On that handshake: op_count+=1, rsp_valid drops, go to IDLE.
  - No new request is accepted in the handshake cycle. The next acceptance is earliest the following cycle.
- Latency: handshake cycle k gives rsp_valid first high in cycle k+2+LAT.
  - ALU_LAT=1: k+3.
  - MUL_LAT=9: k+11.
- Outside ISSUE/WAIT: alu_a/b/op keep their last values and alu_mul_start=0.
- Boundary cases:
  - Requests not accepted stay pending. The requester must hold valid and its payload until ready.
  - Request changes while not accepted are ignored.
  - rsp_ready held low stalls in RESP indefinitely; both req_ready stay low.
  - rsp_ready high before rsp_valid has no effect.
  - All 16 opcodes are legal. Only 1111 uses MUL_LAT.
- Reset mid-operation: abort immediately to reset values.
  - In-flight command and pending response are discarded.
  - op_count is not incremented.

Decomposition:
- Package alu_pkg:
  - Opcode localparams OP_ADD=0000, OP_SUB=0001, OP_BMA=1101, OP_AMB=1110, OP_MUL=1111, plus the logic/reduction codes.
  - Scheduler state encodings.
  - Function op_latency(op) returning the MUL_LAT/ALU_LAT selection.
- One sub-module: rr_arb2.
  - Two-input round-robin arbiter with rr_last state, en (IDLE) and accept update.
  - Outputs grant[1:0] (one-hot or zero).

Test Plan:
- Single add:
  - Stimulus: req0 a=0xE3, b=0x7B, op=0000, accepted in cycle k.
  - Response: alu_a/alu_b/alu_op=0xE3/0x7B/0000 from k+1; rsp_valid at k+3 with rsp_id=0 and rsp_data/rsp_cout equal to alu_s/alu_cout sampled at end of k+2; op_count=1.
- Multiply:
  - Stimulus: req1 a=0x8E, b=0x12, op=1111.
  - Response: alu_mul_start high exactly one cycle (k+1); operands stable k+1..k+9; rsp_valid at k+11; rsp_id=1; rsp_data = model product 0x09FC.
- Contention:
  - Stimulus: both valid continuously after reset, rsp_ready=1.
  - Response: grants alternate 0,1,0,1; no requester served twice in a row while the other waits.
- Backpressure:
  - Stimulus: rsp_ready=0 for 20 cycles.
  - Response: rsp fields stable, both req_ready=0, busy=1; on rsp_ready=1 one handshake only, then IDLE.
- Reset mid-multiply:
  - Stimulus: rst=1 at k+5 of an op=1111 command.
  - Response: next cycle state=IDLE, rsp_valid=0, outputs 0, op_count unchanged; next grant goes to requester 0.
- Wrap:
  - Stimulus: preload op_count to 0xFFFF (force), then complete one op.
  - Response: op_count=0x0000.
